bf_bus_arbiter: RTL and testbench
=================================

BF_BUS_ARBITER -- requirements
Module: bf_bus_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 15, sets the width of the core, host and memory address.
REQ-002 Parameter BUS_WIDTH, default 8, sets the width of every data bus.
REQ-003 clock  in  1  the single clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 run  in  1  host permission for the core to execute.
REQ-006 core_bus_op  in  BusOp  core bus operation: BusNone, BusReadProg, BusReadData, BusWriteData, BusReadIo, BusWriteIo.
REQ-007 core_addr  in  ADDR_WIDTH  core address.
REQ-008 core_val_out  in  BUS_WIDTH  core write data.
REQ-009 core_val_in  out  BUS_WIDTH  read data returned to the core; registered.
REQ-010 core_enable  out  1  core advance strobe.
REQ-011 host_req, host_we, host_prog  in  1 each  host access request level, write flag, and space select (1 = program, 0 = data).
REQ-012 host_addr  in  ADDR_WIDTH; host_wdata  in  BUS_WIDTH; host_rdata  out  BUS_WIDTH; host_ack  out  1.
REQ-013 mem_req, mem_we, mem_space (0 = program, 1 = data)  out  1 each; mem_addr  out  ADDR_WIDTH; mem_wdata  out  BUS_WIDTH; mem_rdata  in  BUS_WIDTH; mem_ack  in  1.
REQ-014 io_out_valid  out  1; io_out_data  out  BUS_WIDTH; io_out_ready  in  1; io_in_valid  in  1; io_in_data  in  BUS_WIDTH; io_in_ready  out  1.

Function
REQ-015 The block SHALL implement the states IDLE, CORE_MEM, CORE_IO_RD, CORE_IO_WR, CORE_GRANT, HOST_MEM and HOST_DONE.
REQ-016 In IDLE, when a core op that is not BusNone is pending with run=1 and a host_req is also pending, the block SHALL grant the requester that was not granted last; last_grant resets to core.
REQ-017 In IDLE, a core grant SHALL register core_addr, core_val_out and the op, then go to CORE_MEM for a Prog or Data op, CORE_IO_RD for BusReadIo, or CORE_IO_WR for BusWriteIo.
REQ-018 In IDLE, a host grant SHALL register host_addr, host_wdata, host_we and host_prog, then go to HOST_MEM.
REQ-019 CORE_MEM and HOST_MEM SHALL hold mem_req=1 with stable registered mem_addr, mem_we, mem_space and mem_wdata until mem_ack=1 is sampled.
REQ-020 The request SHALL complete in the mem_ack cycle; mem_req SHALL be 0 in the next cycle.
REQ-021 On a core read completion (mem or IO), the block SHALL load core_val_in and go to CORE_GRANT.
REQ-022 On a core write completion, the block SHALL go to CORE_GRANT with core_val_in unchanged.
REQ-023 CORE_IO_RD SHALL assert io_in_ready and complete on io_in_valid && io_in_ready, capturing io_in_data.
REQ-024 CORE_IO_WR SHALL assert io_out_valid with the registered data on io_out_data and complete on io_out_valid && io_out_ready.
REQ-025 CORE_GRANT SHALL assert core_enable for exactly one cycle and then return to IDLE, independent of run.
REQ-026 In IDLE, core_enable SHALL equal run && core_bus_op==BusNone && !host_req; it SHALL be 0 in every other state.
REQ-027 core_val_in SHALL hold its value until the next core read completes.
REQ-028 HOST_MEM completion SHALL load host_rdata on reads and go to HOST_DONE.
REQ-029 HOST_DONE SHALL assert host_ack for one cycle and return to IDLE; host_req still high in the following IDLE cycle SHALL count as a new request.
REQ-030 A run=0 level SHALL block new core grants only; any transaction in progress SHALL complete including its CORE_GRANT.
REQ-031 An undefined core_bus_op encoding SHALL be treated as BusNone.
REQ-032 Minimum core read latency SHALL be 3 cycles from op visible in IDLE to the core_enable pulse, with mem_ack in the first mem_req cycle.

Reset
REQ-033 reset_n=0 SHALL immediately force state IDLE, last_grant=core, and every output, core_val_in, host_rdata and all captured registers to 0, including mid-transaction.
REQ-034 After reset_n rises, operation SHALL begin on the next rising clock edge.

Verification
REQ-035 Pulse reset_n low during CORE_MEM wait -> mem_req falls without a clock edge, all outputs 0, IDLE after release.
REQ-036 BusReadProg addr 0x0005, mem_ack in the first mem_req cycle, mem_rdata 0x2B -> mem_space=0, mem_req for one cycle, core_val_in=0x2B, core_enable pulse in cycle 3.
REQ-037 BusWriteIo core_val_out 0x41, io_out_ready low 4 cycles -> io_out_valid and io_out_data=0x41 stable for 5 cycles, core_enable 0 until transfer, one pulse after.
REQ-038 host_req read data addr 0x0010 together with core BusReadData after reset -> host served first (host_ack, host_rdata), core served next, then host wins the following tie.
REQ-039 run=0 with BusReadData pending -> no mem_req, core_enable 0 for 10 cycles; run=1 -> transaction proceeds normally.
REQ-040 run dropped during CORE_IO_RD -> read completes, one core_enable pulse, then core_enable stays 0.

Source files
------------

// File: rtl/bf_bus_arbiter.sv
// Bus arbiter between a core and a host sharing one memory port, plus the core's
// I/O channel. Grants one requester at a time from IDLE, runs the access to completion,
// then returns a one-cycle core_enable pulse or host_ack before accepting new work.
//
// Ports:
//   clock, reset_n            single clock, asynchronous active-low reset
//   run                       host permission for the core to start new bus operations
//   core_bus_op/addr/val_out  core request (op encoding below); core_val_in registered read data
//   core_enable               core advance strobe
//   host_req/we/prog/addr/wdata, host_rdata, host_ack   host access port (prog: 1 = program)
//   mem_req/we/space/addr/wdata, mem_rdata, mem_ack     memory port (space: 0 = program)
//   io_out_valid/data/ready, io_in_valid/data/ready     core I/O handshakes
module bf_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned BUS_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic [2:0]            core_bus_op,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [BUS_WIDTH-1:0]  core_val_out,
  output logic [BUS_WIDTH-1:0]  core_val_in,
  output logic                  core_enable,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic                  host_prog,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [BUS_WIDTH-1:0]  host_wdata,
  output logic [BUS_WIDTH-1:0]  host_rdata,
  output logic                  host_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_space,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0]  mem_wdata,
  input  logic [BUS_WIDTH-1:0]  mem_rdata,
  input  logic                  mem_ack,
  output logic                  io_out_valid,
  output logic [BUS_WIDTH-1:0]  io_out_data,
  input  logic                  io_out_ready,
  input  logic                  io_in_valid,
  input  logic [BUS_WIDTH-1:0]  io_in_data,
  output logic                  io_in_ready
);

  // Core bus operation encoding; 6 and 7 are undefined and behave as BusNone.
  localparam logic [2:0] BusNone      = 3'd0;
  localparam logic [2:0] BusReadProg  = 3'd1;
  localparam logic [2:0] BusReadData  = 3'd2;
  localparam logic [2:0] BusWriteData = 3'd3;
  localparam logic [2:0] BusReadIo    = 3'd4;
  localparam logic [2:0] BusWriteIo   = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StCoreMem,
    StCoreIoRd,
    StCoreIoWr,
    StCoreGrant,
    StHostMem,
    StHostDone
  } state_e;

  state_e                 state_q, state_d;
  logic                   last_host_q;     // 1 when the host received the most recent grant
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [BUS_WIDTH-1:0]   wdata_q;
  logic                   we_q;
  logic                   space_q;
  logic [BUS_WIDTH-1:0]   core_val_q;
  logic [BUS_WIDTH-1:0]   host_rdata_q;

  logic                   op_valid;
  logic                   core_pending;
  logic                   grant_core;
  logic                   grant_host;
  logic                   core_rd_load;
  logic [BUS_WIDTH-1:0]   core_rd_val;
  logic                   host_rd_load;

  always_comb begin
    op_valid     = (core_bus_op != BusNone) && (core_bus_op <= BusWriteIo);
    core_pending = run && op_valid;
    // On a tie the requester that was not granted last wins.
    grant_host   = (state_q == StIdle) && host_req && (!core_pending || !last_host_q);
    grant_core   = (state_q == StIdle) && core_pending && (!host_req || last_host_q);

    state_d      = state_q;
    core_rd_load = 1'b0;
    core_rd_val  = mem_rdata;
    host_rd_load = 1'b0;

    case (state_q)
      StIdle: begin
        if (grant_core) begin
          if (core_bus_op == BusReadIo) begin
            state_d = StCoreIoRd;
          end else if (core_bus_op == BusWriteIo) begin
            state_d = StCoreIoWr;
          end else begin
            state_d = StCoreMem;
          end
        end else if (grant_host) begin
          state_d = StHostMem;
        end
      end
      StCoreMem: begin
        if (mem_ack) begin
          state_d      = StCoreGrant;
          core_rd_load = !we_q;
        end
      end
      StCoreIoRd: begin
        // io_in_ready is asserted throughout this state, so valid alone completes it.
        if (io_in_valid) begin
          state_d      = StCoreGrant;
          core_rd_load = 1'b1;
          core_rd_val  = io_in_data;
        end
      end
      StCoreIoWr: begin
        if (io_out_ready) begin
          state_d = StCoreGrant;
        end
      end
      StCoreGrant: state_d = StIdle;
      StHostMem: begin
        if (mem_ack) begin
          state_d      = StHostDone;
          host_rd_load = !we_q;
        end
      end
      StHostDone: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      last_host_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_core) begin
        last_host_q <= 1'b0;
      end else if (grant_host) begin
        last_host_q <= 1'b1;
      end
    end
  end

  // The core op itself is kept as the service state plus the we/space flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      space_q      <= 1'b0;
      core_val_q   <= '0;
      host_rdata_q <= '0;
    end else begin
      if (grant_core) begin
        addr_q  <= core_addr;
        wdata_q <= core_val_out;
        we_q    <= (core_bus_op == BusWriteData);
        space_q <= (core_bus_op != BusReadProg);
      end else if (grant_host) begin
        addr_q  <= host_addr;
        wdata_q <= host_wdata;
        we_q    <= host_we;
        space_q <= !host_prog;
      end
      if (core_rd_load) begin
        core_val_q <= core_rd_val;
      end
      if (host_rd_load) begin
        host_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_req      = (state_q == StCoreMem) || (state_q == StHostMem);
  assign mem_we       = we_q;
  assign mem_space    = space_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign io_out_valid = (state_q == StCoreIoWr);
  assign io_out_data  = wdata_q;
  assign io_in_ready  = (state_q == StCoreIoRd);
  assign host_ack     = (state_q == StHostDone);
  assign host_rdata   = host_rdata_q;
  assign core_val_in  = core_val_q;

  // reset_n gates the IDLE term so the strobe is low while reset is held.
  assign core_enable = reset_n &&
                       (((state_q == StIdle) && run && !op_valid && !host_req) ||
                        (state_q == StCoreGrant));

endmodule

// File: tb/tb_bf_bus_arbiter.sv
module tb_bf_bus_arbiter;

  localparam logic [2:0] OpNone      = 3'd0;
  localparam logic [2:0] OpReadProg  = 3'd1;
  localparam logic [2:0] OpReadData  = 3'd2;
  localparam logic [2:0] OpWriteData = 3'd3;
  localparam logic [2:0] OpReadIo    = 3'd4;
  localparam logic [2:0] OpWriteIo   = 3'd5;

  logic        clock;
  logic        reset_n;
  logic        run;
  logic [2:0]  core_bus_op;
  logic [14:0] core_addr;
  logic [7:0]  core_val_out;
  logic [7:0]  core_val_in;
  logic        core_enable;
  logic        host_req, host_we, host_prog;
  logic [14:0] host_addr;
  logic [7:0]  host_wdata, host_rdata;
  logic        host_ack;
  logic        mem_req, mem_we, mem_space;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        io_out_valid, io_out_ready, io_in_valid, io_in_ready;
  logic [7:0]  io_out_data, io_in_data;

  int checks = 0;
  int errors = 0;

  // Reference model: two small memories and the values each reader should currently hold.
  logic [7:0] prog_m [32];
  logic [7:0] data_m [32];
  logic [7:0] exp_core;
  logic [7:0] exp_host;

  bf_bus_arbiter #(
    .ADDR_WIDTH(15),
    .BUS_WIDTH (8)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .run         (run),
    .core_bus_op (core_bus_op),
    .core_addr   (core_addr),
    .core_val_out(core_val_out),
    .core_val_in (core_val_in),
    .core_enable (core_enable),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_prog   (host_prog),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .host_ack    (host_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_space   (mem_space),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .io_out_valid(io_out_valid),
    .io_out_data (io_out_data),
    .io_out_ready(io_out_ready),
    .io_in_valid (io_in_valid),
    .io_in_data  (io_in_data),
    .io_in_ready (io_in_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One core transaction from its IDLE cycle through the IDLE cycle after core_enable.
  task automatic core_txn(input logic [2:0] op, input int unsigned addr, input logic [7:0] wd,
                          input int unsigned delay, input bit drop_run);
    bit         is_mem;
    logic [7:0] iov;
    is_mem       = (op == OpReadProg) || (op == OpReadData) || (op == OpWriteData);
    iov          = 8'($urandom);
    run          = 1'b1;
    host_req     = 1'b0;
    core_bus_op  = op;
    core_addr    = 15'(addr);
    core_val_out = wd;
    #1;
    chk("idle_pending_en", 32'(core_enable), 32'd0);
    tick();
    core_bus_op  = OpNone;
    core_addr    = 15'($urandom);
    core_val_out = 8'($urandom);
    if (drop_run) run = 1'b0;
    for (int k = 0; k <= int'(delay); k++) begin
      chk("busy_en", 32'(core_enable), 32'd0);
      if (is_mem) begin
        chk("core_mem_req", 32'(mem_req), 32'd1);
        chk("core_mem_addr", 32'(mem_addr), addr);
        chk("core_mem_space", 32'(mem_space), 32'(op != OpReadProg));
        chk("core_mem_we", 32'(mem_we), 32'(op == OpWriteData));
        if (op == OpWriteData) chk("core_mem_wdata", 32'(mem_wdata), 32'(wd));
        mem_ack   = (k == int'(delay));
        mem_rdata = (k != int'(delay)) ? 8'($urandom) :
                    (op == OpReadProg) ? prog_m[addr] : data_m[addr];
      end else if (op == OpReadIo) begin
        chk("io_in_ready", 32'(io_in_ready), 32'd1);
        chk("io_rd_mem_req", 32'(mem_req), 32'd0);
        io_in_valid = (k == int'(delay));
        io_in_data  = (k == int'(delay)) ? iov : 8'($urandom);
      end else begin
        chk("io_out_valid", 32'(io_out_valid), 32'd1);
        chk("io_out_data", 32'(io_out_data), 32'(wd));
        io_out_ready = (k == int'(delay));
      end
      tick();
    end
    mem_ack      = 1'b0;
    io_in_valid  = 1'b0;
    io_out_ready = 1'b0;
    case (op)
      OpReadProg:  exp_core = prog_m[addr];
      OpReadData:  exp_core = data_m[addr];
      OpWriteData: data_m[addr] = wd;
      OpReadIo:    exp_core = iov;
      default:     ;
    endcase
    chk("grant_en", 32'(core_enable), 32'd1);
    chk("grant_mem_req", 32'(mem_req), 32'd0);
    chk("grant_core_val", 32'(core_val_in), 32'(exp_core));
    chk("grant_io_out_valid", 32'(io_out_valid), 32'd0);
    chk("grant_io_in_ready", 32'(io_in_ready), 32'd0);
    tick();
    chk("after_grant_en", 32'(core_enable), 32'(run));
  endtask

  task automatic host_txn(input bit we, input bit prog, input int unsigned addr,
                          input logic [7:0] wd, input int unsigned delay);
    core_bus_op = OpNone;
    host_req    = 1'b1;
    host_we     = we;
    host_prog   = prog;
    host_addr   = 15'(addr);
    host_wdata  = wd;
    #1;
    chk("host_idle_en", 32'(core_enable), 32'd0);
    tick();
    host_req   = 1'b0;
    host_we    = !we;
    host_addr  = 15'($urandom);
    host_wdata = 8'($urandom);
    for (int k = 0; k <= int'(delay); k++) begin
      chk("host_mem_req", 32'(mem_req), 32'd1);
      chk("host_mem_addr", 32'(mem_addr), addr);
      chk("host_mem_space", 32'(mem_space), 32'(!prog));
      chk("host_mem_we", 32'(mem_we), 32'(we));
      if (we) chk("host_mem_wdata", 32'(mem_wdata), 32'(wd));
      chk("host_ack_early", 32'(host_ack), 32'd0);
      mem_ack   = (k == int'(delay));
      mem_rdata = (k != int'(delay)) ? 8'($urandom) : prog ? prog_m[addr] : data_m[addr];
      tick();
    end
    mem_ack = 1'b0;
    if (we) begin
      if (prog) prog_m[addr] = wd;
      else data_m[addr] = wd;
    end else begin
      exp_host = prog ? prog_m[addr] : data_m[addr];
    end
    chk("host_ack", 32'(host_ack), 32'd1);
    chk("host_rdata", 32'(host_rdata), 32'(exp_host));
    chk("host_done_mem_req", 32'(mem_req), 32'd0);
    chk("host_done_en", 32'(core_enable), 32'd0);
    tick();
    chk("host_ack_once", 32'(host_ack), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b1; core_bus_op = OpNone; core_addr = '0; core_val_out = '0;
    host_req = 1'b0; host_we = 1'b0; host_prog = 1'b0; host_addr = '0; host_wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0; io_out_ready = 1'b0; io_in_valid = 1'b0; io_in_data = '0;
    for (int i = 0; i < 32; i++) begin
      prog_m[i] = 8'($urandom);
      data_m[i] = 8'($urandom);
    end
    exp_core = '0;
    exp_host = '0;

    // Outputs held at zero during reset, even with run=1 and nothing pending.
    #12;
    chk("rst_en", 32'(core_enable), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_core_val", 32'(core_val_in), 32'd0);
    chk("rst_host_rdata", 32'(host_rdata), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_io", 32'({io_out_valid, io_in_ready, host_ack, mem_we, mem_space}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk("idle_en", 32'(core_enable), 32'd1);

    // Host and core tie right after reset: host first, then core, then host again.
    host_req = 1'b1; host_we = 1'b0; host_prog = 1'b0; host_addr = 15'h0010;
    core_bus_op = OpReadData; core_addr = 15'd3;
    #1;
    chk("tie1_en", 32'(core_enable), 32'd0);
    tick();
    chk("tie1_host_addr", 32'(mem_addr), 32'h10);
    chk("tie1_space", 32'(mem_space), 32'd1);
    chk("tie1_we", 32'(mem_we), 32'd0);
    mem_ack = 1'b1; mem_rdata = data_m[16];
    tick();
    mem_ack = 1'b0; exp_host = data_m[16];
    chk("tie1_ack", 32'(host_ack), 32'd1);
    chk("tie1_rdata", 32'(host_rdata), 32'(exp_host));
    tick();
    chk("tie2_idle_en", 32'(core_enable), 32'd0);
    tick();
    chk("tie2_core_addr", 32'(mem_addr), 32'd3);
    chk("tie2_core_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = data_m[3];
    tick();
    mem_ack = 1'b0; exp_core = data_m[3];
    chk("tie2_grant_en", 32'(core_enable), 32'd1);
    chk("tie2_core_val", 32'(core_val_in), 32'(exp_core));
    core_addr = 15'd4;
    tick();
    tick();
    chk("tie3_host_addr", 32'(mem_addr), 32'h10);
    host_req = 1'b0; core_bus_op = OpNone;
    mem_ack = 1'b1; mem_rdata = data_m[16];
    tick();
    mem_ack = 1'b0;
    chk("tie3_ack", 32'(host_ack), 32'd1);
    tick();
    chk("tie3_idle_en", 32'(core_enable), 32'd1);

    // Program read with immediate ack: core_enable in cycle 3.
    prog_m[5] = 8'h2B;
    core_txn(OpReadProg, 5, 8'h00, 0, 1'b0);
    chk("rdprog_val", 32'(core_val_in), 32'h2B);

    // I/O write held off for four cycles.
    core_txn(OpWriteIo, 0, 8'h41, 4, 1'b0);

    // run=0 blocks a pending data read.
    run = 1'b0; core_bus_op = OpReadData; core_addr = 15'd7;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("run0_mem_req", 32'(mem_req), 32'd0);
      chk("run0_en", 32'(core_enable), 32'd0);
      tick();
    end
    core_txn(OpReadData, 7, 8'h00, 1, 1'b0);

    // run dropped mid I/O read: the read still finishes with one pulse.
    core_txn(OpReadIo, 0, 8'h00, 2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("run_dropped_en", 32'(core_enable), 32'd0);
      tick();
    end

    // Reset pulse while waiting for mem_ack.
    run = 1'b1; core_bus_op = OpReadData; core_addr = 15'd9;
    tick();
    core_bus_op = OpNone;
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_en", 32'(core_enable), 32'd0);
    chk("mid_rst_core_val", 32'(core_val_in), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_host_rdata", 32'(host_rdata), 32'd0);
    exp_core = '0;
    exp_host = '0;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk("post_rst_idle_en", 32'(core_enable), 32'd1);
    chk("post_rst_req", 32'(mem_req), 32'd0);

    // Tie priority restarts with the host winning.
    host_req = 1'b1; host_we = 1'b0; host_prog = 1'b0; host_addr = 15'd17;
    core_bus_op = OpReadData; core_addr = 15'd2;
    tick();
    chk("post_rst_tie_addr", 32'(mem_addr), 32'd17);
    host_req = 1'b0; core_bus_op = OpNone;
    mem_ack = 1'b1; mem_rdata = data_m[17];
    tick();
    mem_ack = 1'b0; exp_host = data_m[17];
    chk("post_rst_tie_ack", 32'(host_ack), 32'd1);
    chk("post_rst_tie_rdata", 32'(host_rdata), 32'(exp_host));
    tick();

    // Randomized mix checked against the memory model.
    for (int n = 0; n < 60; n++) begin
      int unsigned kind;
      kind = $urandom_range(0, 7);
      if (kind <= 4) begin
        core_txn(3'(kind + 1), $urandom_range(0, 31), 8'($urandom), $urandom_range(0, 3), 1'b0);
      end else if (kind == 5) begin
        run = 1'b1; host_req = 1'b0;
        core_bus_op = 3'($urandom_range(6, 7));
        #1;
        chk("undef_en", 32'(core_enable), 32'd1);
        tick();
        chk("undef_mem_req", 32'(mem_req), 32'd0);
        chk("undef_io", 32'({io_in_ready, io_out_valid}), 32'd0);
        chk("undef_en2", 32'(core_enable), 32'd1);
        core_bus_op = OpNone;
      end else if (kind == 6) begin
        host_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 31),
                 8'($urandom), $urandom_range(0, 3));
      end else begin
        run = 1'($urandom_range(0, 1));
        core_bus_op = OpNone; host_req = 1'b0;
        #1;
        chk("rand_idle_en", 32'(core_enable), 32'(run));
        tick();
        chk("rand_idle_req", 32'(mem_req), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
